// File: rtl/des_round_sequencer.sv
// Iterative DES round controller: one combinational round reused NUM_ROUNDS times, L/R held in registers.
// Block accepted at edge k is presented on out_block after edge k+NUM_ROUNDS; DONE holds until out_ready.
module des_round_sequencer #(
   parameter int NUM_ROUNDS = 16,
   parameter int IDX_W      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_block,
   input  logic             in_decrypt,
   output logic [IDX_W-1:0] subkey_idx,
   output logic [31:0]      rnd_in_left,
   output logic [31:0]      rnd_in_right,
   input  logic [31:0]      rnd_out_left,
   input  logic [31:0]      rnd_out_right,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_block,
   output logic             busy,
   output logic [IDX_W-1:0] round_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_ROUNDS - 1);

   state_t           state, state_nxt;
   logic [31:0]      l_q, r_q;
   logic [IDX_W-1:0] cnt_q;
   logic             mode_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      subkey_idx = '0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            // Decrypt walks the key schedule backwards; mode is the latched copy.
            subkey_idx = mode_q ? (LAST_CNT - cnt_q) : cnt_q;
            if (cnt_q == LAST_CNT) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            busy      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_q    <= '0;
         r_q    <= '0;
         cnt_q  <= '0;
         mode_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  l_q    <= in_block[63:32];
                  r_q    <= in_block[31:0];
                  mode_q <= in_decrypt;
                  cnt_q  <= '0;
               end
            end
            RUN: begin
               l_q   <= rnd_out_left;
               r_q   <= rnd_out_right;
               cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign rnd_in_left  = l_q;
   assign rnd_in_right = r_q;
   // Final L/R swap happens here so the round stays uniform.
   assign out_block    = {r_q, l_q};
   assign round_cnt    = cnt_q;

endmodule
